// File: rtl/wb_lsu_pkg.sv
// Shared encodings for the Wishbone load/store unit: access sizes, FSM states,
// default ack timeout and the alignment rule.
package wb_lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int DEFAULT_TIMEOUT = 255;

  // Size 2'b11 is not a legal access and is reported like a misaligned one.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/wb_lsu_if.sv
// Pipelined Wishbone master bus as seen by the load/store unit.
interface wb_lsu_if #(
  parameter int addr_width = 16
);
  logic [addr_width-1:0] wb_addr_o;
  logic [31:0]           wb_data_o;
  logic [31:0]           wb_data_i;
  logic                  wb_we_o;
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic [3:0]            wb_sel_o;
  logic                  wb_ack_i;
  logic                  wb_stall_i;

  // Handshake: a cycle transfers while stb=1 and stall=0; completion is ack=1
  // while stb=1, and an ack seen with stb=0 is ignored by the master.
  modport master (
    output wb_addr_o, wb_data_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_sel_o,
    input  wb_data_i, wb_ack_i, wb_stall_i
  );

  modport slave (
    input  wb_addr_o, wb_data_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_sel_o,
    output wb_data_i, wb_ack_i, wb_stall_i
  );
endinterface

// File: rtl/wb_lsu_align.sv
// Byte-lane logic: select mask and store replication for the outgoing request,
// lane extraction and sign/zero extension for the returning load data.
module wb_lsu_align
  import wb_lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    sel       = 4'b0000;
    wdata_rep = st_wdata;
    case (st_size)
      SIZE_BYTE: begin
        sel       = 4'b0001 << st_addr_lo;
        wdata_rep = {4{st_wdata[7:0]}};
      end
      SIZE_HALF: begin
        sel       = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{st_wdata[15:0]}};
      end
      SIZE_WORD: sel = 4'b1111;
      default:   sel = 4'b0000;
    endcase
  end

  always_comb begin
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_data = ld_rdata;
    case (ld_size)
      SIZE_BYTE: ld_data = ld_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data = ld_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default:   ld_data = ld_rdata;
    endcase
  end
endmodule

// File: rtl/wb_lsu.sv
// Single-outstanding load/store unit: turns one CPU request into one Wishbone
// pipelined cycle and returns a one-cycle completion pulse.
module wb_lsu
  import wb_lsu_pkg::*;
#(
  parameter int addr_width  = 16,
  parameter int rdata_delay = 1,
  parameter int timeout     = DEFAULT_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [1:0]  dbg_state_o,
  wb_lsu_if.master    wb
);
  localparam int CNT_W = $clog2(timeout + 1);

  logic [1:0]            state;
  logic [CNT_W-1:0]      bus_cnt;
  logic [1:0]            addr_lo_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic                  we_q;
  logic [addr_width-1:0] wb_addr_q;
  logic [3:0]            sel_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic [3:0]            sel_c;
  logic [31:0]           wdata_c;
  logic [31:0]           ld_data_c;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^req_addr_i[31:addr_width+2];

  wb_lsu_align u_align (
    .st_size     (req_size_i),
    .st_addr_lo  (req_addr_i[1:0]),
    .st_wdata    (req_wdata_i),
    .sel         (sel_c),
    .wdata_rep   (wdata_c),
    .ld_size     (size_q),
    .ld_addr_lo  (addr_lo_q),
    .ld_unsigned (unsigned_q),
    .ld_rdata    (wb.wb_data_i),
    .ld_data     (ld_data_c)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= ST_IDLE;
      bus_cnt    <= '0;
      addr_lo_q  <= 2'b00;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      wb_addr_q  <= '0;
      sel_q      <= 4'b0000;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid_i) begin
          addr_lo_q  <= req_addr_i[1:0];
          size_q     <= req_size_i;
          unsigned_q <= req_unsigned_i;
          we_q       <= req_we_i;
          bus_cnt    <= '0;
          if (is_misaligned(req_size_i, req_addr_i[1:0])) begin
            state   <= ST_DONE;
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
          end else begin
            state     <= ST_BUS;
            wb_addr_q <= req_addr_i[addr_width+1:2];
            sel_q     <= sel_c;
            wdata_q   <= wdata_c;
          end
        end
        // stb is high for the whole of BUS, so any ack here is an accepted one.
        ST_BUS: if (wb.wb_ack_i) begin
          if (we_q) begin
            state   <= ST_DONE;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
          end else if (rdata_delay == 0) begin
            state   <= ST_DONE;
            err_q   <= 1'b0;
            rdata_q <= ld_data_c;
          end else begin
            state <= ST_DATA;
          end
        end else if (bus_cnt == CNT_W'(timeout - 1)) begin
          state   <= ST_DONE;
          err_q   <= 1'b1;
          rdata_q <= 32'h0;
        end else begin
          bus_cnt <= bus_cnt + 1'b1;
        end
        ST_DATA: begin
          state   <= ST_DONE;
          err_q   <= 1'b0;
          rdata_q <= ld_data_c;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state == ST_IDLE);
  assign rsp_valid_o  = (state == ST_DONE);
  assign rsp_rdata_o  = rdata_q;
  assign rsp_err_o    = err_q;
  assign dbg_state_o  = state;

  assign wb.wb_addr_o = wb_addr_q;
  assign wb.wb_data_o = wdata_q;
  assign wb.wb_we_o   = we_q;
  assign wb.wb_sel_o  = sel_q;
  assign wb.wb_cyc_o  = (state == ST_BUS) || (state == ST_DATA);
  assign wb.wb_stb_o  = (state == ST_BUS);
endmodule

// File: tb/tb_wb_lsu.sv
// Directed bench for wb_lsu (rdata_delay=1, timeout=8): stores, loads, alignment
// errors, stall, ack timeout and mid-cycle reset.
module tb_wb_lsu;
  import wb_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  logic [31:0] exp_q[$];

  wb_lsu_if #(.addr_width(16)) wb ();

  wb_lsu #(.addr_width(16), .rdata_delay(1), .timeout(8)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_addr_i     (req_addr),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .dbg_state_o    (dbg_state),
    .wb             (wb)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  // driver tasks
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    chk("ready_idle", req_ready, 1'b1);
    tick;
    req_valid = 1'b0;
    cyc_cnt   = 1;
    chk("ready_busy", req_ready, 1'b0);
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat, input logic exp_err);
    logic [31:0] exp;
    while (!rsp_valid && cyc_cnt < 40) tick;
    chk({tag, "_lat"}, cyc_cnt, exp_lat);
    chk({tag, "_err"}, rsp_err, exp_err);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    chk({tag, "_rdata"}, rsp_rdata, exp);
    tick;
    chk({tag, "_pulse"}, rsp_valid, 1'b0);
  endtask

  task automatic store_seq(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata,
                           input logic [3:0] exp_sel, input logic [31:0] exp_data);
    do_req(1'b1, addr, size, 1'b0, wdata);
    chk("st_stb", wb.wb_stb_o, 1'b1);
    chk("st_we", wb.wb_we_o, 1'b1);
    chk("st_sel", wb.wb_sel_o, exp_sel);
    chk("st_data", wb.wb_data_o, exp_data);
    chk("st_addr", wb.wb_addr_o, addr[17:2]);
    wb.wb_ack_i = 1'b1;
    tick;
    wb.wb_ack_i = 1'b0;
    exp_q.push_back(32'h0);
    wait_rsp("st", 2, 1'b0);
  endtask

  task automatic load_seq(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                          input logic [31:0] rdata, input logic [3:0] exp_sel, input logic [31:0] exp);
    do_req(1'b0, addr, size, uns, 32'h0);
    chk("ld_stb", wb.wb_stb_o, 1'b1);
    chk("ld_we", wb.wb_we_o, 1'b0);
    chk("ld_sel", wb.wb_sel_o, exp_sel);
    chk("ld_addr", wb.wb_addr_o, addr[17:2]);
    wb.wb_ack_i  = 1'b1;
    wb.wb_data_i = ~rdata;
    tick;
    wb.wb_ack_i = 1'b0;
    chk("ld_data_cyc", wb.wb_cyc_o, 1'b1);
    chk("ld_data_stb", wb.wb_stb_o, 1'b0);
    wb.wb_data_i = rdata;
    tick;
    wb.wb_data_i = $urandom;
    exp_q.push_back(exp);
    wait_rsp("ld", 3, 1'b0);
  endtask

  task automatic misaligned_seq(input logic [31:0] addr, input logic [1:0] size);
    do_req(1'b0, addr, size, 1'b0, 32'h0);
    chk("mis_cyc", wb.wb_cyc_o, 1'b0);
    chk("mis_stb", wb.wb_stb_o, 1'b0);
    exp_q.push_back(32'h0);
    wait_rsp("mis", 1, 1'b1);
  endtask

  initial begin
    int n;
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_we        = 1'b0;
    req_addr      = 32'h0;
    req_size      = SIZE_BYTE;
    req_unsigned  = 1'b0;
    req_wdata     = 32'h0;
    wb.wb_data_i  = 32'h0;
    wb.wb_ack_i   = 1'b0;
    wb.wb_stall_i = 1'b0;
    tick;
    tick;
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_cyc", wb.wb_cyc_o, 1'b0);
    chk("rst_stb", wb.wb_stb_o, 1'b0);
    chk("rst_we", wb.wb_we_o, 1'b0);
    chk("rst_sel", wb.wb_sel_o, 4'h0);
    chk("rst_addr", wb.wb_addr_o, 16'h0);
    chk("rst_wdata", wb.wb_data_o, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;
    tick;

    // stores
    store_seq(32'h0000_0003, SIZE_BYTE, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB);
    store_seq(32'h0000_0001, SIZE_BYTE, 32'hFFFF_FF5A, 4'b0010, 32'h5A5A_5A5A);
    store_seq(32'h0000_0102, SIZE_HALF, 32'hFFFF_1234, 4'b1100, 32'h1234_1234);
    store_seq(32'h0000_0200, SIZE_WORD, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

    // loads
    load_seq(32'h0000_0006, SIZE_HALF, 1'b0, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
    load_seq(32'h0000_0002, SIZE_HALF, 1'b1, 32'h8001_0000, 4'b1100, 32'h0000_8001);
    load_seq(32'h0000_0000, SIZE_HALF, 1'b0, 32'h1234_F00D, 4'b0011, 32'hFFFF_F00D);
    load_seq(32'h0000_0001, SIZE_BYTE, 1'b0, 32'h0000_8000, 4'b0010, 32'hFFFF_FF80);
    load_seq(32'h0000_0001, SIZE_BYTE, 1'b1, 32'h0000_8000, 4'b0010, 32'h0000_0080);
    load_seq(32'h0000_0002, SIZE_BYTE, 1'b0, 32'h007F_0000, 4'b0100, 32'h0000_007F);
    load_seq(32'h0000_0008, SIZE_WORD, 1'b0, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    // alignment errors
    misaligned_seq(32'h0000_0005, SIZE_WORD);
    misaligned_seq(32'h0000_0003, SIZE_HALF);
    misaligned_seq(32'h0000_0000, 2'b11);

    // stall for three cycles, ack on the fourth
    do_req(1'b1, 32'h0000_0010, SIZE_WORD, 1'b0, 32'h1234_5678);
    n = 0;
    for (int i = 1; i <= 4; i++) begin
      chk("stall_stb", wb.wb_stb_o, 1'b1);
      chk("stall_addr", wb.wb_addr_o, 16'h0004);
      chk("stall_sel", wb.wb_sel_o, 4'b1111);
      chk("stall_rsp", rsp_valid, 1'b0);
      if (wb.wb_stb_o) n++;
      wb.wb_stall_i = (i < 4);
      wb.wb_ack_i   = (i == 4);
      tick;
    end
    wb.wb_stall_i = 1'b0;
    wb.wb_ack_i   = 1'b0;
    chk("stall_stb_cycles", n, 4);
    exp_q.push_back(32'h0);
    wait_rsp("stall", 5, 1'b0);

    // ack never arrives
    do_req(1'b0, 32'h0000_0021, SIZE_BYTE, 1'b1, 32'h0);
    n = 0;
    while (wb.wb_cyc_o && n < 20) begin
      n++;
      tick;
    end
    chk("to_cyc_cycles", n, 8);
    chk("to_stb", wb.wb_stb_o, 1'b0);
    exp_q.push_back(32'h0);
    wait_rsp("timeout", 9, 1'b1);

    // reset in the middle of BUS, then a stray ack
    do_req(1'b0, 32'h0000_0040, SIZE_WORD, 1'b0, 32'h0);
    chk("mr_cyc_before", wb.wb_cyc_o, 1'b1);
    rst_n = 1'b0;
    tick;
    chk("mr_cyc", wb.wb_cyc_o, 1'b0);
    chk("mr_stb", wb.wb_stb_o, 1'b0);
    chk("mr_rsp", rsp_valid, 1'b0);
    chk("mr_err", rsp_err, 1'b0);
    chk("mr_addr", wb.wb_addr_o, 16'h0);
    chk("mr_state", dbg_state, ST_IDLE);
    rst_n       = 1'b1;
    wb.wb_ack_i = 1'b1;
    tick;
    wb.wb_ack_i = 1'b0;
    chk("late_ack_rsp", rsp_valid, 1'b0);
    chk("late_ack_ready", req_ready, 1'b1);
    tick;
    chk("late_ack_rsp2", rsp_valid, 1'b0);

    // unit still works after the abort
    store_seq(32'h0000_0006, SIZE_HALF, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_lsu.md
WB_LSU -- requirements
Module: wb_lsu

Interface
REQ-001 SHALL have parameter addr_width, default 16, Wishbone word-address width.
REQ-002 SHALL have parameter rdata_delay, default 1, cycles from accepted ack to valid wb_data_i (0 or 1).
REQ-003 SHALL have parameter timeout, default 255, max cycles waiting for ack before error.
REQ-004 SHALL have ports: clk_i in 1 clock; rst_n_i in 1 reset. One clock; reset is synchronous and active-low.
REQ-005 SHALL have ports: req_valid_i in 1 request valid; req_ready_o out 1 request accepted; req_we_i in 1 store=1; req_addr_i in 32 byte address; req_size_i in 2 00 byte/01 half/10 word; req_unsigned_i in 1 zero-extend load; req_wdata_i in 32 store data, right-aligned.
REQ-006 SHALL have ports: rsp_valid_o out 1 completion pulse; rsp_rdata_o out 32 extended load data; rsp_err_o out 1 misaligned or timeout.
REQ-007 SHALL have ports: wb_addr_o out addr_width word address; wb_data_o out 32; wb_data_i in 32; wb_we_o out 1; wb_cyc_o out 1; wb_stb_o out 1; wb_sel_o out 4; wb_ack_i in 1; wb_stall_i in 1.

Function
REQ-008 SHALL implement FSM IDLE, BUS, DATA, DONE; req_ready_o=1 only in IDLE.
REQ-009 SHALL, in IDLE with req_valid_i, latch request; go DONE with err=1 if misaligned (half addr[0]=1, word addr[1:0]!=0, size=11), else BUS.
REQ-010 SHALL drive wb_addr_o=req_addr_i[addr_width+1:2], registered, stable from BUS entry to DONE.
REQ-011 SHALL generate wb_sel_o: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100; word 1111; sel driven for reads too.
REQ-012 SHALL replicate store data across lanes: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
REQ-013 SHALL assert wb_cyc_o and wb_stb_o throughout BUS; stb held while wb_stall_i=1.
REQ-014 SHALL treat ack as accepted only when wb_ack_i=1 and wb_stb_o=1 in BUS; ack outside BUS/stb ignored.
REQ-015 SHALL on accepted ack: store -> DONE; load with rdata_delay=0 -> capture wb_data_i same cycle, DONE; rdata_delay=1 -> DATA (stb=0, cyc=1), capture wb_data_i there, DONE.
REQ-016 SHALL extract load lane by addr[1:0]; sign-extend from bit 7/15 unless req_unsigned_i=1; word unchanged.
REQ-017 SHALL count BUS cycles; on reaching timeout without ack -> drop cyc/stb, DONE with err=1, rdata=0.
REQ-018 SHALL in DONE: rsp_valid_o=1 for exactly one cycle, cyc/stb=0, then IDLE; no response back-pressure.
REQ-019 SHALL hold rsp_rdata_o/rsp_err_o until next DONE; rsp_rdata_o=0 for stores and errors.
REQ-020 SHALL latency (zero-stall, ack in first BUS cycle): store rsp 2 cycles after accept; load rsp 2+rdata_delay cycles; misaligned rsp 1 cycle.
REQ-021 SHALL not issue a new request in DONE; back-to-back requests separated by at least one IDLE cycle.

Reset
REQ-022 SHALL on rst_n_i=0 at a clock edge: state IDLE; cyc/stb/we=0, sel=0, wb_addr_o=0, wb_data_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, counters 0.
REQ-023 SHALL on reset mid-transaction abort without response; late ack after reset ignored.

Structure
REQ-024 SHALL place size encodings, state encoding, default timeout in package wb_lsu_pkg.
REQ-025 SHALL put lane logic (sel, store replication, load extract/extend) in combinational sub-module wb_lsu_align.

Verification
REQ-026 SHALL test: store byte addr 0x0000_0003 data 0xAB -> wb_sel_o=1000, wb_data_o=0xABABABAB, wb_addr_o=0, rsp 2 cycles after accept.
REQ-027 SHALL test: load half signed addr 0x6, rdata_delay=1, wb_data_i=0x8001_0000 after ack -> rsp_rdata_o=0xFFFF8001, rsp 3 cycles after accept.
REQ-028 SHALL test: load word addr 0x5 -> no cyc/stb, rsp_err_o=1 next cycle.
REQ-029 SHALL test: wb_stall_i=1 for 3 cycles then ack -> stb held 4 cycles, single rsp pulse, addr/sel stable.
REQ-030 SHALL test: no ack, timeout=8 -> cyc drops after 8 BUS cycles, rsp_err_o=1; rst_n_i=0 mid-BUS -> cyc=0 next edge, no rsp_valid_o.
